// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper: FSM state encoding,
// record-field widths and the settle-counter width helper.
package truth_table_sweeper_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DRIVE  = 3'd1,
      ST_SAMPLE = 3'd2,
      ST_REPORT = 3'd3,
      ST_DONE   = 3'd4
   } tt_state_e;

   localparam int MAX_N_IN = 4;
   localparam int EXPECT_W = 1 << MAX_N_IN;
   localparam int EXP_IDX_W = MAX_N_IN;

   // Counter width able to hold SETTLE-1, never narrower than one bit.
   function automatic int settle_cnt_w(input int settle);
      return (settle < 2) ? 1 : $clog2(settle + 1);
   endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_counter.sv
// Settle-time counter: loads SETTLE-1, counts down while enabled, flags zero.
module settle_counter
   import truth_table_sweeper_pkg::*;
#(
   parameter int SETTLE = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic dec,
   output logic zero
);

   localparam int CW = settle_cnt_w(SETTLE);
   localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= LOAD_VAL;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus/check stage for an N-input combinational gate: drives every
// input vector, samples the response, streams one record per vector, reports pass/fail.
module truth_table_sweeper
   import truth_table_sweeper_pkg::*;
#(
   parameter int                    N_IN   = 2,
   parameter int                    SETTLE = 1,
   parameter logic [EXPECT_W-1:0]   EXPECT = 16'h0007
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic [N_IN-1:0] drive_vec,
   input  logic            dut_out,
   output logic            rec_valid,
   input  logic            rec_ready,
   output logic [N_IN-1:0] rec_vec,
   output logic            rec_out,
   output logic            rec_ok,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_count
);

   localparam logic [N_IN-1:0] VEC_LAST = '1;

   tt_state_e       state;
   logic [N_IN-1:0] vec;
   logic            cnt_load;
   logic            cnt_dec;
   logic            cnt_zero;
   logic            xfer;
   logic            exp_bit;
   logic [N_IN:0]   err_next;

   assign xfer     = (state == ST_REPORT) && rec_valid && rec_ready;
   assign cnt_load = ((state == ST_IDLE) && start) || (xfer && (vec != VEC_LAST));
   assign cnt_dec  = (state == ST_DRIVE);
   assign exp_bit  = EXPECT[EXP_IDX_W'(vec)];
   // Error count including the record transferring this cycle, so pass sees it.
   assign err_next = err_count + {{N_IN{1'b0}}, (xfer & ~rec_ok)};

   settle_counter #(
      .SETTLE (SETTLE)
   ) u_settle (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (cnt_load),
      .dec   (cnt_dec),
      .zero  (cnt_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         vec       <= '0;
         drive_vec <= '0;
         rec_valid <= 1'b0;
         rec_vec   <= '0;
         rec_out   <= 1'b0;
         rec_ok    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  vec       <= '0;
                  drive_vec <= '0;
                  err_count <= '0;
                  pass      <= 1'b0;
                  busy      <= 1'b1;
                  state     <= ST_DRIVE;
               end
            end
            ST_DRIVE: begin
               if (cnt_zero) begin
                  state <= ST_SAMPLE;
               end
            end
            ST_SAMPLE: begin
               rec_vec   <= vec;
               rec_out   <= dut_out;
               rec_ok    <= (dut_out == exp_bit);
               rec_valid <= 1'b1;
               state     <= ST_REPORT;
            end
            ST_REPORT: begin
               // Record and drive_vec stay frozen for as long as the logger stalls.
               if (xfer) begin
                  rec_valid <= 1'b0;
                  err_count <= err_next;
                  if (vec == VEC_LAST) begin
                     done      <= 1'b1;
                     busy      <= 1'b0;
                     drive_vec <= '0;
                     pass      <= (err_next == '0);
                     state     <= ST_DONE;
                  end else begin
                     vec       <= vec + 1'b1;
                     drive_vec <= vec + 1'b1;
                     state     <= ST_DRIVE;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: 2-input NAND sweeper (faults, stalls, reset, restart) and a
// 3-input AND sweeper with a longer settle time.
module tb_truth_table_sweeper;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic st0 = 1'b0;
   logic st1 = 1'b0;
   logic rr = 1'b1;
   logic stuck = 1'b0;

   logic [1:0] dv0, rv0;
   logic [2:0] dv1, rv1;
   logic [2:0] ec0;
   logic [3:0] ec1;
   logic dout0, dout1;
   logic val0, out0, ok0, busy0, done0, pass0;
   logic val1, out1, ok1, busy1, done1, pass1;

   int n_checks = 0;
   int n_fail = 0;

   logic       sel = 1'b0;
   logic       s_valid, s_out, s_ok, s_done, s_pass, s_busy;
   logic [3:0] s_vec, s_drv, s_err;

   logic [3:0] r_vec [16];
   logic       r_out [16];
   logic       r_ok  [16];
   int nrec, done_cyc, ndone;

   always #5 clk = ~clk;

   assign dout0 = stuck ? 1'b1 : ~&dv0;
   assign dout1 = &dv1;

   truth_table_sweeper #(.N_IN(2), .SETTLE(1), .EXPECT(16'h0007)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(st0), .drive_vec(dv0), .dut_out(dout0),
      .rec_valid(val0), .rec_ready(rr), .rec_vec(rv0), .rec_out(out0), .rec_ok(ok0),
      .busy(busy0), .done(done0), .pass(pass0), .err_count(ec0)
   );

   truth_table_sweeper #(.N_IN(3), .SETTLE(3), .EXPECT(16'h0080)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(st1), .drive_vec(dv1), .dut_out(dout1),
      .rec_valid(val1), .rec_ready(rr), .rec_vec(rv1), .rec_out(out1), .rec_ok(ok1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(ec1)
   );

   assign s_valid = sel ? val1  : val0;
   assign s_out   = sel ? out1  : out0;
   assign s_ok    = sel ? ok1   : ok0;
   assign s_done  = sel ? done1 : done0;
   assign s_pass  = sel ? pass1 : pass0;
   assign s_busy  = sel ? busy1 : busy0;
   assign s_vec   = sel ? 4'(rv1) : 4'(rv0);
   assign s_drv   = sel ? 4'(dv1) : 4'(dv0);
   assign s_err   = sel ? ec1 : 4'(ec0);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_start(input logic v);
      if (sel) st1 = v;
      else st0 = v;
   endtask

   // Runs one sweep; logs every handshaken record. stall_vec/stall_n hold ready
   // low on that vector's record; restart_at re-pulses start at that cycle.
   task automatic sweep(input int stall_vec, input int stall_n, input int restart_at);
      int stall_left;
      nrec = 0;
      done_cyc = 0;
      ndone = 0;
      stall_left = stall_n;
      rr = 1'b1;
      set_start(1'b1);
      for (int cyc = 1; cyc <= 200; cyc++) begin
         tick();
         if (cyc == 1) set_start(1'b0);
         if (cyc == restart_at) set_start(1'b1);
         if (restart_at > 1 && cyc == restart_at + 1) set_start(1'b0);
         if (s_done) begin
            ndone++;
            if (done_cyc == 0) done_cyc = cyc;
         end
         if (s_valid) begin
            if (int'(s_vec) == stall_vec && stall_left > 0) begin
               rr = 1'b0;
               stall_left--;
               check("stall_rec_vec", s_vec, 4'(stall_vec));
               check("stall_drive_vec", s_drv, 4'(stall_vec));
            end else begin
               rr = 1'b1;
               if (nrec < 16) begin
                  r_vec[nrec] = s_vec;
                  r_out[nrec] = s_out;
                  r_ok[nrec]  = s_ok;
               end
               nrec++;
            end
         end else begin
            rr = 1'b1;
         end
         if (done_cyc != 0 && cyc >= done_cyc + 3) break;
      end
      set_start(1'b0);
      rr = 1'b1;
   endtask

   initial begin
      logic [3:0] nand_out [4];
      nand_out = '{1'b1, 1'b1, 1'b1, 1'b0};

      // Reset state
      tick();
      tick();
      check("reset_dut0", {dv0, val0, rv0, out0, ok0, busy0, done0, pass0, ec0}, 0);
      check("reset_dut1", {dv1, val1, rv1, out1, ok1, busy1, done1, pass1, ec1}, 0);
      rst_n = 1'b1;
      tick();

      // 1) NAND, EXPECT=0111
      sel = 1'b0;
      sweep(-1, 0, 0);
      check("t1_nrec", nrec, 4);
      check("t1_done_cyc", done_cyc, 13);
      check("t1_ndone", ndone, 1);
      for (int i = 0; i < 4; i++) begin
         check("t1_vec", r_vec[i], i);
         check("t1_out", r_out[i], nand_out[i]);
         check("t1_ok", r_ok[i], 1);
      end
      check("t1_pass", s_pass, 1);
      check("t1_err", s_err, 0);
      check("t1_busy", s_busy, 0);
      check("t1_drive_idle", s_drv, 0);
      tick();
      check("t1_pass_held", s_pass, 1);

      // 2) stuck-at-1 gate
      stuck = 1'b1;
      sweep(-1, 0, 0);
      stuck = 1'b0;
      check("t2_nrec", nrec, 4);
      check("t2_ok0", r_ok[0], 1);
      check("t2_ok2", r_ok[2], 1);
      check("t2_out3", r_out[3], 1);
      check("t2_ok3", r_ok[3], 0);
      check("t2_err", s_err, 1);
      check("t2_pass", s_pass, 0);

      // 3) logger stalls 5 cycles on the vec 01 record
      sweep(1, 5, 0);
      check("t3_nrec", nrec, 4);
      for (int i = 0; i < 4; i++) check("t3_vec", r_vec[i], i);
      check("t3_done_cyc", done_cyc, 18);
      check("t3_pass", s_pass, 1);

      // 5) start re-pulsed mid-sweep
      sweep(-1, 0, 5);
      check("t5_nrec", nrec, 4);
      check("t5_ndone", ndone, 1);
      check("t5_done_cyc", done_cyc, 13);
      check("t5_err", s_err, 0);

      // 4) reset during DRIVE of vec 10
      st0 = 1'b1;
      tick();
      st0 = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      check("t4_pre_drive", dv0, 2'b10);
      check("t4_pre_busy", busy0, 1);
      rst_n = 1'b0;
      #2;
      check("t4_async_clear", {dv0, val0, rv0, out0, ok0, busy0, done0, pass0, ec0}, 0);
      tick();
      rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done0) ndone++;
      end
      check("t4_no_done", ndone, 0);
      check("t4_pass_low", pass0, 0);
      sweep(-1, 0, 0);
      check("t4_nrec", nrec, 4);
      check("t4_first_vec", r_vec[0], 0);
      check("t4_last_vec", r_vec[3], 3);
      check("t4_done_cyc", done_cyc, 13);
      check("t4_pass", s_pass, 1);

      // 6) 3-input AND, SETTLE=3
      sel = 1'b1;
      sweep(-1, 0, 0);
      check("t6_nrec", nrec, 8);
      check("t6_done_cyc", done_cyc, 41);
      check("t6_ndone", ndone, 1);
      for (int i = 0; i < 8; i++) begin
         check("t6_vec", r_vec[i], i);
         check("t6_out", r_out[i], (i == 7) ? 1 : 0);
         check("t6_ok", r_ok[i], 1);
      end
      check("t6_pass", s_pass, 1);
      check("t6_err", s_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
